// File: rtl/alu_result_checker.sv
// alu_result_checker: on-chip scoreboard for the n-bit ALU family.
// Expected results are queued in order. Each ALU result is compared with the
// queue head, and the outcome feeds saturating statistics counters.
// Optional feature macro: ALU_RESULT_CHECKER_FIRST_ERR_EN. When it is defined,
// the queue also stores the operands, and the first mismatch is captured.
module alu_result_checker #(
    parameter int DATA_WIDTH   = 4,
    parameter int RESULT_WIDTH = 2 * DATA_WIDTH,
    parameter int OP_WIDTH     = 3,
    parameter int NUM_OPS      = 4,
    parameter int EXP_DEPTH    = 8,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          exp_valid,
    output logic                          exp_ready,
    input  logic [DATA_WIDTH-1:0]         exp_a,
    input  logic [DATA_WIDTH-1:0]         exp_b,
    input  logic [OP_WIDTH-1:0]           exp_op,
    input  logic [RESULT_WIDTH-1:0]       exp_result,
    input  logic                          res_valid,
    input  logic [RESULT_WIDTH-1:0]       res_result,
    output logic [$clog2(EXP_DEPTH):0]    exp_count,
    output logic [NUM_OPS*CNT_WIDTH-1:0]  match_cnt,
    output logic [CNT_WIDTH-1:0]          other_cnt,
    output logic [CNT_WIDTH-1:0]          mismatch_cnt,
    output logic [CNT_WIDTH-1:0]          underflow_cnt,
    output logic [CNT_WIDTH-1:0]          total_cnt,
    output logic                          err_sticky,
    output logic                          first_err_valid,
    output logic [CNT_WIDTH-1:0]          first_err_index,
    output logic [DATA_WIDTH-1:0]         first_err_a,
    output logic [DATA_WIDTH-1:0]         first_err_b,
    output logic [OP_WIDTH-1:0]           first_err_op,
    output logic [RESULT_WIDTH-1:0]       first_err_got,
    output logic [RESULT_WIDTH-1:0]       first_err_exp
);

    localparam int AW = $clog2(EXP_DEPTH);

    // Counter increment that holds at all-ones.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic [OP_WIDTH-1:0]     op_mem  [EXP_DEPTH];
    logic [RESULT_WIDTH-1:0] res_mem [EXP_DEPTH];

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          full, empty, push, pop;
    logic          is_match, hit, miss, underflow;
    logic [OP_WIDTH-1:0]     head_op;
    logic [RESULT_WIDTH-1:0] head_res;
    logic [31:0]             head_op_ext;

    assign full      = (count_q == (AW + 1)'(EXP_DEPTH));
    assign empty     = (count_q == '0);
    assign exp_ready = ~full;
    assign exp_count = count_q;
    assign push      = exp_valid & ~full;
    assign pop       = res_valid & ~empty;

    // The head entry is read without a register stage, so the result
    // arriving on the same edge can be compared against it.
    assign head_op     = op_mem[rd_ptr_q];
    assign head_res    = res_mem[rd_ptr_q];
    assign head_op_ext = 32'(head_op);
    assign is_match    = (res_result == head_res);
    // A clr in the same cycle still pops, but the statistics are discarded.
    assign hit         = pop & is_match & ~clr;
    assign miss        = pop & ~is_match & ~clr;
    assign underflow   = res_valid & empty & ~clr;

    // Queue storage write; a pushed entry is visible at the head next cycle.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr_q]  <= exp_op;
            res_mem[wr_ptr_q] <= exp_result;
        end
    end

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
    end

    // Pointers and occupancy; clr does not touch the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // One saturating match counter per counted opcode.
    logic [CNT_WIDTH-1:0] match_q [NUM_OPS];
    genvar gi;
    generate
        for (gi = 0; gi < NUM_OPS; gi++) begin : g_match
            // Count matches whose head opcode equals this slot.
            always_ff @(posedge clk) begin
                if (rst || clr)                          match_q[gi] <= '0;
                else if (hit && head_op_ext == 32'(gi))  match_q[gi] <= sat_inc(match_q[gi]);
            end
            assign match_cnt[gi*CNT_WIDTH +: CNT_WIDTH] = match_q[gi];
        end
    endgenerate

    logic [CNT_WIDTH-1:0] other_q, mismatch_q, underflow_q, total_q;
    logic                 err_q;

    // Shared statistics and the sticky error flag.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            other_q     <= '0;
            mismatch_q  <= '0;
            underflow_q <= '0;
            total_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            if (hit && head_op_ext >= 32'(NUM_OPS)) other_q <= sat_inc(other_q);
            if (miss)      mismatch_q  <= sat_inc(mismatch_q);
            if (underflow) underflow_q <= sat_inc(underflow_q);
            if (hit || miss) total_q   <= sat_inc(total_q);
            if (miss || underflow) err_q <= 1'b1;
        end
    end

    assign other_cnt     = other_q;
    assign mismatch_cnt  = mismatch_q;
    assign underflow_cnt = underflow_q;
    assign total_cnt     = total_q;
    assign err_sticky    = err_q;

`ifdef ALU_RESULT_CHECKER_FIRST_ERR_EN
    logic [DATA_WIDTH-1:0]   a_mem [EXP_DEPTH];
    logic [DATA_WIDTH-1:0]   b_mem [EXP_DEPTH];
    logic                    fe_valid_q;
    logic [CNT_WIDTH-1:0]    fe_index_q;
    logic [DATA_WIDTH-1:0]   fe_a_q, fe_b_q;
    logic [OP_WIDTH-1:0]     fe_op_q;
    logic [RESULT_WIDTH-1:0] fe_got_q, fe_exp_q;

    // Operand storage, kept only for the capture registers.
    always_ff @(posedge clk) begin
        if (push) begin
            a_mem[wr_ptr_q] <= exp_a;
            b_mem[wr_ptr_q] <= exp_b;
        end
    end

    // Capture the first mismatch; later mismatches leave it alone.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            fe_valid_q <= 1'b0;
            fe_index_q <= '0;
            fe_a_q     <= '0;
            fe_b_q     <= '0;
            fe_op_q    <= '0;
            fe_got_q   <= '0;
            fe_exp_q   <= '0;
        end else if (miss && !fe_valid_q) begin
            fe_valid_q <= 1'b1;
            fe_index_q <= total_q;
            fe_a_q     <= a_mem[rd_ptr_q];
            fe_b_q     <= b_mem[rd_ptr_q];
            fe_op_q    <= head_op;
            fe_got_q   <= res_result;
            fe_exp_q   <= head_res;
        end
    end

    assign first_err_valid = fe_valid_q;
    assign first_err_index = fe_index_q;
    assign first_err_a     = fe_a_q;
    assign first_err_b     = fe_b_q;
    assign first_err_op    = fe_op_q;
    assign first_err_got   = fe_got_q;
    assign first_err_exp   = fe_exp_q;
`else
    // Without the capture feature, the operands are not stored.
    logic unused_operands;
    assign unused_operands = ^{exp_a, exp_b};

    assign first_err_valid = 1'b0;
    assign first_err_index = '0;
    assign first_err_a     = '0;
    assign first_err_b     = '0;
    assign first_err_op    = '0;
    assign first_err_got   = '0;
    assign first_err_exp   = '0;
`endif

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed-vector bench for alu_result_checker.
// CNT_WIDTH is reduced to 4 so that saturation is reachable quickly.
module tb_alu_result_checker;

    localparam int DW = 4;
    localparam int RW = 8;
    localparam int OW = 3;
    localparam int NO = 4;
    localparam int ED = 8;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              rst, clr;
    logic              exp_valid, exp_ready;
    logic [DW-1:0]     exp_a, exp_b;
    logic [OW-1:0]     exp_op;
    logic [RW-1:0]     exp_result;
    logic              res_valid;
    logic [RW-1:0]     res_result;
    logic [3:0]        exp_count;
    logic [NO*CW-1:0]  match_cnt;
    logic [CW-1:0]     other_cnt, mismatch_cnt, underflow_cnt, total_cnt;
    logic              err_sticky, first_err_valid;
    logic [CW-1:0]     first_err_index;
    logic [DW-1:0]     first_err_a, first_err_b;
    logic [OW-1:0]     first_err_op;
    logic [RW-1:0]     first_err_got, first_err_exp;

    int total_checks = 0;
    int bad_checks   = 0;

    always #5 clk = ~clk;

    alu_result_checker #(
        .DATA_WIDTH(DW), .RESULT_WIDTH(RW), .OP_WIDTH(OW),
        .NUM_OPS(NO), .EXP_DEPTH(ED), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .exp_valid(exp_valid), .exp_ready(exp_ready),
        .exp_a(exp_a), .exp_b(exp_b), .exp_op(exp_op), .exp_result(exp_result),
        .res_valid(res_valid), .res_result(res_result),
        .exp_count(exp_count), .match_cnt(match_cnt),
        .other_cnt(other_cnt), .mismatch_cnt(mismatch_cnt),
        .underflow_cnt(underflow_cnt), .total_cnt(total_cnt),
        .err_sticky(err_sticky), .first_err_valid(first_err_valid),
        .first_err_index(first_err_index),
        .first_err_a(first_err_a), .first_err_b(first_err_b),
        .first_err_op(first_err_op),
        .first_err_got(first_err_got), .first_err_exp(first_err_exp)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total_checks++;
        if (got !== want) begin
            bad_checks++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [OW-1:0] op, input logic [RW-1:0] r);
        exp_valid = 1'b1; exp_a = a; exp_b = b; exp_op = op; exp_result = r;
        tick();
        exp_valid = 1'b0;
    endtask

    task automatic result(input logic [RW-1:0] r);
        res_valid = 1'b1; res_result = r;
        tick();
        res_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    function automatic logic [CW-1:0] mslice(input int k);
        return match_cnt[k*CW +: CW];
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clr = 1'b0; exp_valid = 1'b0; res_valid = 1'b0;
        exp_a = '0; exp_b = '0; exp_op = '0; exp_result = '0; res_result = '0;
        tick(); tick();
        check("rst_ready", 32'(exp_ready), 32'd1);
        check("rst_count", 32'(exp_count), 32'd0);
        check("rst_match", 32'(match_cnt), 32'd0);
        check("rst_total", 32'(total_cnt), 32'd0);
        check("rst_mis", 32'(mismatch_cnt), 32'd0);
        check("rst_under", 32'(underflow_cnt), 32'd0);
        check("rst_other", 32'(other_cnt), 32'd0);
        check("rst_err", 32'(err_sticky), 32'd0);
        check("rst_fev", 32'(first_err_valid), 32'd0);
        rst = 1'b0;
        tick();

        // Single add match: 3 + (-2) = 1.
        push(4'h3, 4'hE, 3'd0, 8'h01);
        check("push1_count", 32'(exp_count), 32'd1);
        result(8'h01);
        check("m0", 32'(mslice(0)), 32'd1);
        check("m0_total", 32'(total_cnt), 32'd1);
        check("m0_err", 32'(err_sticky), 32'd0);
        check("m0_count", 32'(exp_count), 32'd0);

        // Two mismatches, with the capture starting from a cleared state.
        pulse_clr();
        push(4'hD, 4'h5, 3'd2, 8'hF1);
        push(4'h1, 4'h1, 3'd3, 8'h02);
        result(8'hF0);
        result(8'h03);
        check("mis_cnt", 32'(mismatch_cnt), 32'd2);
        check("mis_total", 32'(total_cnt), 32'd2);
        check("mis_err", 32'(err_sticky), 32'd1);
        check("mis_m", 32'(match_cnt), 32'd0);
`ifdef ALU_RESULT_CHECKER_FIRST_ERR_EN
        check("fe_valid", 32'(first_err_valid), 32'd1);
        check("fe_index", 32'(first_err_index), 32'd0);
        check("fe_a", 32'(first_err_a), 32'hD);
        check("fe_b", 32'(first_err_b), 32'h5);
        check("fe_op", 32'(first_err_op), 32'd2);
        check("fe_got", 32'(first_err_got), 32'hF0);
        check("fe_exp", 32'(first_err_exp), 32'hF1);
`else
        check("fe_valid_off", 32'(first_err_valid), 32'd0);
        check("fe_got_off", 32'(first_err_got), 32'd0);
`endif

        // Fill, overflow attempt, pop, simultaneous push and pop, then drain.
        pulse_clr();
        for (int i = 0; i < 8; i++) push(4'h0, 4'h0, 3'd1, 8'(i));
        check("full_count", 32'(exp_count), 32'd8);
        check("full_ready", 32'(exp_ready), 32'd0);
        push(4'h0, 4'h0, 3'd0, 8'hAA);
        check("ovf_count", 32'(exp_count), 32'd8);
        result(8'h00);
        check("pop_count", 32'(exp_count), 32'd7);
        check("pop_ready", 32'(exp_ready), 32'd1);
        exp_valid = 1'b1; exp_op = 3'd1; exp_result = 8'h08;
        res_valid = 1'b1; res_result = 8'h01;
        tick();
        exp_valid = 1'b0; res_valid = 1'b0;
        check("pp_count", 32'(exp_count), 32'd7);
        for (int i = 2; i < 9; i++) result(8'(i));
        check("drain_m1", 32'(mslice(1)), 32'd9);
        check("drain_mis", 32'(mismatch_cnt), 32'd0);
        check("drain_count", 32'(exp_count), 32'd0);

        // Underflow, then clr.
        result(8'h55);
        check("uf_cnt", 32'(underflow_cnt), 32'd1);
        check("uf_err", 32'(err_sticky), 32'd1);
        check("uf_total", 32'(total_cnt), 32'd9);
        check("uf_count", 32'(exp_count), 32'd0);
        pulse_clr();
        check("clr_uf", 32'(underflow_cnt), 32'd0);
        check("clr_err", 32'(err_sticky), 32'd0);
        check("clr_total", 32'(total_cnt), 32'd0);
        check("clr_match", 32'(match_cnt), 32'd0);

        // A clr coinciding with a result pops but discards the statistics.
        push(4'h0, 4'h0, 3'd0, 8'h11);
        clr = 1'b1; res_valid = 1'b1; res_result = 8'h22;
        tick();
        clr = 1'b0; res_valid = 1'b0;
        check("clrpop_count", 32'(exp_count), 32'd0);
        check("clrpop_mis", 32'(mismatch_cnt), 32'd0);
        check("clrpop_err", 32'(err_sticky), 32'd0);

        // Saturation of the sub counter at 4'hF.
        for (int i = 0; i < 17; i++) begin
            push(4'h0, 4'h0, 3'd1, 8'(i + 16));
            result(8'(i + 16));
        end
        check("sat_m1", 32'(mslice(1)), 32'hF);
        check("sat_total", 32'(total_cnt), 32'hF);
        push(4'h0, 4'h0, 3'd5, 8'h77);
        result(8'h77);
        check("other", 32'(other_cnt), 32'd1);
        check("other_m1", 32'(mslice(1)), 32'hF);

        // Reset with three entries queued.
        for (int i = 0; i < 3; i++) push(4'h0, 4'h0, 3'd0, 8'(i));
        check("pre_rst_count", 32'(exp_count), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_count", 32'(exp_count), 32'd0);
        check("mid_rst_m1", 32'(mslice(1)), 32'd0);
        result(8'h00);
        check("post_rst_uf", 32'(underflow_cnt), 32'd1);
        check("post_rst_total", 32'(total_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/alu_result_checker.md
# alu_result_checker

Synthesizable, parametrised self-checking scoreboard for the n-bit ALU family. It queues expected results, consumes the ALU's result stream in order, and compares each result against the queue head. It keeps per-opcode match counters, mismatch and underflow counters, and an optional first-mismatch capture. It sits beside the ALU in FPGA bring-up builds, replacing file-based golden comparison with an on-chip checker readable over debug registers.

## Interface
Parameters:
- DATA_WIDTH, 4, ALU operand width (signed).
- RESULT_WIDTH, 2*DATA_WIDTH, ALU result width.
- OP_WIDTH, 3, opcode width.
- NUM_OPS, 4, opcodes 0..NUM_OPS-1 counted individually (0 add, 1 sub, 2 mul, 3 div); higher opcodes go to the other counter.
- EXP_DEPTH, 8, expected-queue depth; power of 2, at least 2.
- CNT_WIDTH, 16, width of every statistics counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- clr  in  1  synchronous clear of statistics and error state; queue untouched.
- exp_valid  in  1  expected entry offered.
- exp_ready  out  1  queue can accept an entry (~full).
- exp_a, exp_b  in  DATA_WIDTH  operands, stored for capture.
- exp_op  in  OP_WIDTH  opcode.
- exp_result  in  RESULT_WIDTH  golden result.
- res_valid  in  1  ALU result present; no backpressure.
- res_result  in  RESULT_WIDTH  ALU result.
- exp_count  out  $clog2(EXP_DEPTH)+1  queue occupancy.
- match_cnt  out  NUM_OPS*CNT_WIDTH  per-opcode matches; opcode k occupies slice [k*CNT_WIDTH +: CNT_WIDTH].
- other_cnt, mismatch_cnt, underflow_cnt, total_cnt  out  CNT_WIDTH  statistics.
- err_sticky  out  1  any mismatch or underflow since reset/clr.
- first_err_valid  out  1  capture registers hold data.
- first_err_index  out  CNT_WIDTH  total_cnt value at the first mismatch.
- first_err_a, first_err_b  out  DATA_WIDTH; first_err_op  out  OP_WIDTH; first_err_got, first_err_exp  out  RESULT_WIDTH.

## Operation
- Queue: circular buffer with wrapping read/write pointers. A push happens when exp_valid & exp_ready. A pop happens when res_valid & exp_count != 0. Push and pop in the same cycle leave the count unchanged. When full, exp_ready is 0 and exp_valid is ignored.
- Compare: res_result == head.exp_result, full RESULT_WIDTH, bitwise.
- Match: increment match_cnt[head.op] if op < NUM_OPS, else increment other_cnt. Increment total_cnt.
- Mismatch: increment mismatch_cnt and total_cnt; set err_sticky. If first_err_valid is 0, capture index = pre-increment total_cnt, a, b, op, got, exp, and set first_err_valid. Later mismatches never overwrite the capture.
- res_valid with an empty queue: increment underflow_cnt, set err_sticky, no pop, total_cnt unchanged.
- All counters saturate at all-ones.
- clr: zeroes all counters, err_sticky and capture. If clr coincides with res_valid, the pop still occurs but its statistics are discarded. Queue and pointers are unaffected by clr.
- rst: empties the queue and zeroes every register.

## Timing
- Reset values: every output is 0 except exp_ready = 1.
- Comparison uses the head entry combinationally at the res_valid edge. Counters, err_sticky and capture update on that edge and are visible the next cycle (1-cycle latency).
- An entry pushed in cycle N can be popped in cycle N+1 at the earliest; no write-to-read bypass.
- exp_ready and exp_count reflect registered occupancy. A pop in cycle N frees a slot visible in cycle N+1.
- Reset mid-stream: queued entries are discarded; results arriving afterwards count as underflow.

## Configuration
- ALU_RESULT_CHECKER_FIRST_ERR_EN defined: first-mismatch capture registers and the stored a/b fields in the queue are built.
- Undefined: queue stores only op and result. first_err_* outputs and first_err_valid are tied to 0. All counters and err_sticky behave identically.

## Test plan
All scenarios use DATA_WIDTH=4, RESULT_WIDTH=8, EXP_DEPTH=8.
- Reset with rst=1 for 2 cycles -> all outputs 0, exp_ready=1, exp_count=0.
- Push a=3, b=-2, op=0, exp=8'h01; next cycle res_result=8'h01 -> match_cnt[0]=1, total_cnt=1, err_sticky=0, exp_count=0.
- Push op=2, a=-3, b=5, exp=8'hF1, then push op=3, exp=8'h02. Results 8'hF0 then 8'h03 -> mismatch_cnt=2, err_sticky=1; capture holds index 0, a=-3, b=5, op=2, got F0, exp F1.
- Push 8 entries -> exp_count=8, exp_ready=0; a 9th exp_valid is ignored. One res_valid -> exp_count=7, exp_ready=1 the next cycle. Push+pop in the same cycle -> count stays 7.
- res_valid=1 with an empty queue -> underflow_cnt=1, err_sticky=1, total_cnt=0, exp_count=0. Then clr -> all statistics 0, err_sticky=0.
- Force match_cnt[1] to all-ones via long stream (or reduced CNT_WIDTH=2) -> further sub matches hold at 2'b11. Reset asserted with 3 queued entries -> exp_count=0 the next cycle.
